router_fsm_ctrl: RTL and testbench
==================================

// Module: router_fsm_ctrl
// PURPOSE
//  Packet-sequencing controller for the 1x3 router ingress path.
//  Decodes the 2-bit destination in each header, waits for the target output FIFO to drain,
//  then sequences the header, payload and parity loads.
//  Throttles the source via busy while the selected FIFO is full, and aborts on soft reset or wait timeout.
//  Drives the address-capture, write-enable and load-stage strobes that feed the synchronizer and register stage.
// PARAMETERS
//  WAIT_MAX   64  max cycles in WAIT_TILL_EMPTY before packet is dropped (>=1)
//  WCNT_W     7   width of wait counter; must hold WAIT_MAX
// PORTS
//  clk            in   1  rising-edge clock
//  rst            in   1  async active-high reset
//  pkt_valid      in   1  source has header/payload byte on bus
//  din            in   2  destination address bits of header byte (3 = invalid)
//  fifo_full      in   1  full flag of currently selected FIFO (from synchronizer)
//  fifo_empty_0   in   1  output FIFO 0 empty
//  fifo_empty_1   in   1  output FIFO 1 empty
//  fifo_empty_2   in   1  output FIFO 2 empty
//  soft_reset_0   in   1  FIFO 0 read-timeout reset
//  soft_reset_1   in   1  FIFO 1 read-timeout reset
//  soft_reset_2   in   1  FIFO 2 read-timeout reset
//  parity_done    in   1  register stage has latched parity byte
//  low_pkt_valid  in   1  pkt_valid fell while FIFO was full (parity pending)
//  detect_addr    out  1  state==DECODE_ADDRESS
//  lfd_state      out  1  state==LOAD_FIRST_DATA
//  ld_state       out  1  state==LOAD_DATA
//  laf_state      out  1  state==LOAD_AFTER_FULL
//  full_state     out  1  state==FIFO_FULL_STATE
//  write_enb_reg  out  1  LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
//  rst_int_reg    out  1  state==CHECK_PARITY_ERROR
//  busy           out  1  1 in all states except DECODE_ADDRESS and LOAD_DATA
//  drop_pkt       out  1  1-cycle pulse: packet abandoned (timeout or invalid addr)
// BEHAVIOUR
//  - Moore FSM; all outputs decoded from the state register only. No output depends on inputs.
//  - Reset: state=DECODE_ADDRESS, addr_q=0, wait_cnt=0, drop_pkt=0.
//    Hence detect_addr=1 and all other outputs 0 during/after reset.
//  - addr_q (2b) captured on cycle when detect_addr&pkt_valid&din!=3.
//    sel_empty = fifo_empty_[addr_q]; sel_srst = soft_reset_[addr_q].
//  - DECODE_ADDRESS:
//    - pkt_valid&din==k&fifo_empty_k -> LOAD_FIRST_DATA.
//    - pkt_valid&din==k&!fifo_empty_k -> WAIT_TILL_EMPTY.
//    - pkt_valid&din==3 -> stay, drop_pkt pulse.
//    - else stay.
//  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally (1 cycle).
//  - LOAD_DATA:
//    - fifo_full -> FIFO_FULL_STATE.
//    - else !pkt_valid -> LOAD_PARITY.
//    - else stay.
//  - LOAD_PARITY -> CHECK_PARITY_ERROR (1 cycle).
//  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
//  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
//  - LOAD_AFTER_FULL:
//    - parity_done -> DECODE_ADDRESS.
//    - else low_pkt_valid -> LOAD_PARITY.
//    - else -> LOAD_DATA.
//  - WAIT_TILL_EMPTY:
//    - wait_cnt cleared on entry, +1 per cycle.
//    - sel_empty -> LOAD_FIRST_DATA; checked before timeout, so empty on the limit cycle wins.
//    - else wait_cnt==WAIT_MAX-1 -> DECODE_ADDRESS, drop_pkt pulse.
//    - wait_cnt saturates; never wraps.
//  - sel_srst in any state except DECODE_ADDRESS -> DECODE_ADDRESS next cycle. Highest priority, no drop_pkt.
//    soft_reset of a non-selected FIFO is ignored.
//  - rst asserted mid-packet: immediate return to reset values; no strobe glitches beyond async clear.
//  - drop_pkt registered: high exactly one cycle after the dropping transition.
// TESTING
//  - Reset then idle: rst=1 2 cycles, release -> detect_addr=1, busy=0, all other strobes 0.
//  - din=1, fifo_empty_1=1, pkt_valid 5 cycles then 0:
//    DA->LFD->LD x4->LP->CPE->DA; write_enb_reg=1 for 5 cycles total; rst_int_reg=1 for 1 cycle.
//  - fifo_full=1 in 3rd LD cycle for 4 cycles, low_pkt_valid=1:
//    FFS held 4 cycles, busy=1, then LAF->LP->CPE->DA.
//  - din=2, fifo_empty_2=0 for 10 cycles then 1: WAIT_TILL_EMPTY 10 cycles, then LFD; drop_pkt stays 0.
//  - din=0, fifo_empty_0 held 0, WAIT_MAX=64: back to DA after 64 wait cycles; drop_pkt=1 for exactly 1 cycle.
//  - soft_reset_1 during LD with addr_q=1 -> DA next cycle; soft_reset_0 at the same point -> no effect.

Source files
------------

// File: rtl/router_fsm_ctrl.sv
// router_fsm_ctrl
//   Packet-sequencing controller for the 1x3 router ingress path. It decodes
//   the 2-bit destination carried in each header and waits for that output
//   FIFO to drain. It then sequences the header, payload and parity loads.
//   While the selected FIFO is full it throttles the source through busy.
//   A packet is abandoned on a soft reset of the selected FIFO, on a wait
//   timeout, or on an invalid destination.
//
// Handshake: the source presents a byte whenever pkt_valid is high. A byte is
//   accepted on a rising clk edge with pkt_valid=1 and busy=0. busy acts as
//   the inverted ready, and it is a pure function of the state register.
//
// Parameters
//   WAIT_MAX  max cycles spent in WAIT_TILL_EMPTY before the packet is dropped
//   WCNT_W    width of the wait counter (must hold WAIT_MAX-1)
//
// Ports
//   clk, rst                      clock, async active-high reset
//   pkt_valid                     source has a header/payload byte on the bus
//   din[1:0]                      destination bits of header (3 = invalid)
//   fifo_full                     full flag of the selected FIFO
//   fifo_empty_0/1/2              output FIFO empty flags
//   soft_reset_0/1/2              output FIFO read-timeout resets
//   parity_done                   register stage has latched the parity byte
//   low_pkt_valid                 pkt_valid fell while FIFO was full
//   detect_addr .. full_state     one-hot state strobes
//   write_enb_reg                 FIFO write enable (LD | LP | LAF)
//   rst_int_reg                   internal reset strobe (CHECK_PARITY_ERROR)
//   busy                          source throttle
//   drop_pkt                      registered 1-cycle packet-abandon pulse
//   state_dbg[2:0]                raw state register for observation
module router_fsm_ctrl #(
  parameter int WAIT_MAX = 64,
  parameter int WCNT_W   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] din,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       drop_pkt,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_t;

  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        addr_q;
  logic [WCNT_W-1:0] wait_cnt;
  logic              drop_nxt;
  logic              sel_empty;
  logic              sel_srst;
  logic              din_empty;

  // Flags of the FIFO latched for the current packet. addr_q is never 3,
  // because invalid headers are not captured.
  always_comb begin
    sel_empty = 1'b0;
    sel_srst  = 1'b0;
    case (addr_q)
      2'd0: begin sel_empty = fifo_empty_0; sel_srst = soft_reset_0; end
      2'd1: begin sel_empty = fifo_empty_1; sel_srst = soft_reset_1; end
      2'd2: begin sel_empty = fifo_empty_2; sel_srst = soft_reset_2; end
      default: begin sel_empty = 1'b0; sel_srst = 1'b0; end
    endcase
  end

  // Empty flag of the FIFO named by the header currently on the bus.
  always_comb begin
    din_empty = 1'b0;
    case (din)
      2'd0:    din_empty = fifo_empty_0;
      2'd1:    din_empty = fifo_empty_1;
      2'd2:    din_empty = fifo_empty_2;
      default: din_empty = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= DECODE_ADDRESS;
      addr_q   <= 2'd0;
      wait_cnt <= '0;
      drop_pkt <= 1'b0;
    end else begin
      state    <= state_nxt;
      drop_pkt <= drop_nxt;
      if (state == DECODE_ADDRESS && pkt_valid && din != 2'd3)
        addr_q <= din;
      // The counter is held at zero outside the wait state, so every entry
      // starts counting from 0. It saturates at the limit instead of wrapping.
      if (state != WAIT_TILL_EMPTY)
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_LAST)
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    drop_nxt  = 1'b0;
    // A soft reset of the selected FIFO beats every other transition,
    // including a timeout that falls on the same cycle.
    if (state != DECODE_ADDRESS && sel_srst) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (pkt_valid) begin
            if (din == 2'd3)   drop_nxt  = 1'b1;
            else if (din_empty) state_nxt = LOAD_FIRST_DATA;
            else                state_nxt = WAIT_TILL_EMPTY;
          end
        end
        LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        end
        LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: begin
          if (fifo_full) state_nxt = FIFO_FULL_STATE;
          else           state_nxt = DECODE_ADDRESS;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        end
        WAIT_TILL_EMPTY: begin
          // Emptiness is tested first, so a drain on the limit cycle still wins.
          if (sel_empty) begin
            state_nxt = LOAD_FIRST_DATA;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = DECODE_ADDRESS;
            drop_nxt  = 1'b1;
          end
        end
        default: state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  assign detect_addr   = (state == DECODE_ADDRESS);
  assign lfd_state     = (state == LOAD_FIRST_DATA);
  assign ld_state      = (state == LOAD_DATA);
  assign laf_state     = (state == LOAD_AFTER_FULL);
  assign full_state    = (state == FIFO_FULL_STATE);
  assign write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                         (state == LOAD_AFTER_FULL);
  assign rst_int_reg   = (state == CHECK_PARITY_ERROR);
  assign busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  assign state_dbg     = state;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
module tb_router_fsm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] din;
  logic       fifo_full;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       detect_addr, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy, drop_pkt;
  logic [2:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  // Observed strobes: {detect_addr, lfd, ld, laf, full, write_enb, rst_int, busy}
  logic [7:0] obs;
  assign obs = {detect_addr, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy};

  localparam logic [7:0] O_DA  = 8'b1000_0000;
  localparam logic [7:0] O_LFD = 8'b0100_0001;
  localparam logic [7:0] O_LD  = 8'b0010_0100;
  localparam logic [7:0] O_LAF = 8'b0001_0101;
  localparam logic [7:0] O_FFS = 8'b0000_1001;
  localparam logic [7:0] O_LP  = 8'b0000_0101;
  localparam logic [7:0] O_CPE = 8'b0000_0011;
  localparam logic [7:0] O_WTE = 8'b0000_0001;

  router_fsm_ctrl #(.WAIT_MAX(64), .WCNT_W(7)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .din(din),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0),
    .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done),
    .low_pkt_valid(low_pkt_valid), .detect_addr(detect_addr),
    .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .drop_pkt(drop_pkt),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Outputs are sampled and inputs changed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pkt_valid = 1'b0; din = 2'd0; fifo_full = 1'b0;
    fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
    soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
    parity_done = 1'b0; low_pkt_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    #2 rst = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== O_DA) begin
      failures++; $display("FAIL reset_hold strobes: got %b want %b", obs, O_DA);
    end
    checks++;
    if (drop_pkt !== 1'b0) begin
      failures++; $display("FAIL reset_hold drop_pkt: got %b want 0", drop_pkt);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== O_DA) begin
      failures++; $display("FAIL reset_idle strobes: got %b want %b", obs, O_DA);
    end
  endtask

  // Plain packet: header to FIFO 1, pkt_valid high for 5 cycles.
  task automatic test_normal_packet();
    logic [0:0] pv [8];
    logic [7:0] expv [8];
    int we_cnt, ri_cnt;
    pv   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    expv = '{O_LFD, O_LD, O_LD, O_LD, O_LD, O_LP, O_CPE, O_DA};
    we_cnt = 0; ri_cnt = 0;
    din = 2'd1; fifo_empty_1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pkt_valid = pv[k][0];
      tick();
      if (write_enb_reg === 1'b1) we_cnt++;
      if (rst_int_reg === 1'b1) ri_cnt++;
      checks++;
      if (obs !== expv[k]) begin
        failures++; $display("FAIL normal step %0d: got %b want %b", k, obs, expv[k]);
      end
    end
    checks++;
    if (we_cnt != 5) begin
      failures++; $display("FAIL normal write_enb cycles: got %0d want 5", we_cnt);
    end
    checks++;
    if (ri_cnt != 1) begin
      failures++; $display("FAIL normal rst_int cycles: got %0d want 1", ri_cnt);
    end
  endtask

  // FIFO goes full in the 3rd LOAD_DATA cycle for 4 cycles; parity still pending.
  task automatic test_fifo_full();
    logic [3:0] stim [12];  // {pkt_valid, fifo_full, low_pkt_valid, parity_done}
    logic [7:0] expv [12];
    stim = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100,
             4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
    expv = '{O_LFD, O_LD, O_LD, O_LD, O_FFS, O_FFS,
             O_FFS, O_FFS, O_LAF, O_LP, O_CPE, O_DA};
    din = 2'd1; fifo_empty_1 = 1'b1;
    for (int k = 0; k < 12; k++) begin
      {pkt_valid, fifo_full, low_pkt_valid, parity_done} = stim[k];
      tick();
      checks++;
      if (obs !== expv[k]) begin
        failures++; $display("FAIL fifo_full step %0d: got %b want %b", k, obs, expv[k]);
      end
    end
    idle_inputs();
  endtask

  // Other LOAD_AFTER_FULL exits, plus CHECK_PARITY_ERROR going to FIFO_FULL_STATE.
  task automatic test_laf_branches();
    logic [3:0] stim [10];
    logic [7:0] expv [10];
    stim = '{4'b1000, 4'b1000, 4'b1100, 4'b1000, 4'b1000,
             4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0001};
    expv = '{O_LFD, O_LD, O_FFS, O_LAF, O_LD,
             O_LP, O_CPE, O_FFS, O_LAF, O_DA};
    din = 2'd1; fifo_empty_1 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      {pkt_valid, fifo_full, low_pkt_valid, parity_done} = stim[k];
      tick();
      checks++;
      if (obs !== expv[k]) begin
        failures++; $display("FAIL laf_branch step %0d: got %b want %b", k, obs, expv[k]);
      end
    end
    idle_inputs();
  endtask

  // FIFO 2 is not empty: wait 10 cycles, then it drains.
  task automatic test_wait_empty();
    int drops;
    drops = 0;
    din = 2'd2; fifo_empty_2 = 1'b0; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    checks++;
    if (obs !== O_WTE) begin
      failures++; $display("FAIL wait_enter: got %b want %b", obs, O_WTE);
    end
    for (int i = 0; i < 9; i++) begin
      if (drop_pkt !== 1'b0) drops++;
      tick();
      checks++;
      if (obs !== O_WTE) begin
        failures++; $display("FAIL wait_hold cycle %0d: got %b want %b", i + 2, obs, O_WTE);
      end
    end
    fifo_empty_2 = 1'b1;
    tick();
    if (drop_pkt !== 1'b0) drops++;
    checks++;
    if (obs !== O_LFD) begin
      failures++; $display("FAIL wait_release: got %b want %b", obs, O_LFD);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (drop_pkt !== 1'b0) drops++;
    end
    checks++;
    if (obs !== O_DA) begin
      failures++; $display("FAIL wait_finish: got %b want %b", obs, O_DA);
    end
    checks++;
    if (drops != 0) begin
      failures++; $display("FAIL wait_no_drop: got %0d drop cycles want 0", drops);
    end
    idle_inputs();
  endtask

  // FIFO 0 never drains: the packet is dropped after 64 wait cycles.
  task automatic test_timeout();
    int wte_cycles, early_drops;
    wte_cycles = 0; early_drops = 0;
    din = 2'd0; fifo_empty_0 = 1'b0; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0;
    for (int i = 0; i < 80 && obs === O_WTE; i++) begin
      wte_cycles++;
      if (drop_pkt !== 1'b0) early_drops++;
      tick();
    end
    checks++;
    if (wte_cycles != 64) begin
      failures++; $display("FAIL timeout wait_cycles: got %0d want 64", wte_cycles);
    end
    checks++;
    if (obs !== O_DA) begin
      failures++; $display("FAIL timeout return: got %b want %b", obs, O_DA);
    end
    checks++;
    if (drop_pkt !== 1'b1) begin
      failures++; $display("FAIL timeout drop_pulse: got %b want 1", drop_pkt);
    end
    checks++;
    if (early_drops != 0) begin
      failures++; $display("FAIL timeout early_drop: got %0d want 0", early_drops);
    end
    tick();
    checks++;
    if (drop_pkt !== 1'b0) begin
      failures++; $display("FAIL timeout drop_width: got %b want 0", drop_pkt);
    end
    idle_inputs();
  endtask

  // An invalid destination stays in decode and pulses drop_pkt once.
  task automatic test_invalid_addr();
    din = 2'd3; pkt_valid = 1'b1;
    tick();
    pkt_valid = 1'b0; din = 2'd0;
    checks++;
    if (obs !== O_DA) begin
      failures++; $display("FAIL invalid_addr state: got %b want %b", obs, O_DA);
    end
    checks++;
    if (drop_pkt !== 1'b1) begin
      failures++; $display("FAIL invalid_addr drop: got %b want 1", drop_pkt);
    end
    tick();
    checks++;
    if (drop_pkt !== 1'b0) begin
      failures++; $display("FAIL invalid_addr drop_width: got %b want 0", drop_pkt);
    end
  endtask

  // Only the soft reset of the selected FIFO aborts; none applies in decode.
  task automatic test_soft_reset();
    din = 2'd1; fifo_empty_1 = 1'b1; pkt_valid = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== O_LD) begin
      failures++; $display("FAIL srst setup: got %b want %b", obs, O_LD);
    end
    soft_reset_0 = 1'b1;
    tick();
    soft_reset_0 = 1'b0;
    checks++;
    if (obs !== O_LD) begin
      failures++; $display("FAIL srst other_fifo: got %b want %b", obs, O_LD);
    end
    soft_reset_1 = 1'b1;
    tick();
    checks++;
    if (obs !== O_DA) begin
      failures++; $display("FAIL srst selected: got %b want %b", obs, O_DA);
    end
    checks++;
    if (drop_pkt !== 1'b0) begin
      failures++; $display("FAIL srst no_drop: got %b want 0", drop_pkt);
    end
    // soft_reset_1 is still high: the decode state ignores it, so the header is accepted.
    tick();
    checks++;
    if (obs !== O_LFD) begin
      failures++; $display("FAIL srst in_decode: got %b want %b", obs, O_LFD);
    end
    tick();
    checks++;
    if (obs !== O_DA) begin
      failures++; $display("FAIL srst from_lfd: got %b want %b", obs, O_DA);
    end
    idle_inputs();
    tick();
  endtask

  // An asynchronous reset in mid-packet clears the state without a clock edge.
  task automatic test_mid_reset();
    din = 2'd1; fifo_empty_1 = 1'b1; pkt_valid = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== O_LD) begin
      failures++; $display("FAIL mid_reset setup: got %b want %b", obs, O_LD);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (obs !== O_DA) begin
      failures++; $display("FAIL mid_reset async: got %b want %b", obs, O_DA);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    tick();
    checks++;
    if (obs !== O_DA || drop_pkt !== 1'b0) begin
      failures++; $display("FAIL mid_reset after: got %b/%b want %b/0", obs, drop_pkt, O_DA);
    end
  endtask

  initial begin
    test_reset();
    test_normal_packet();
    test_fifo_full();
    test_laf_branches();
    test_wait_empty();
    test_timeout();
    test_invalid_addr();
    test_soft_reset();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
